// File: rtl/sdram_init_seq_gen_pkg.sv
// Shared types and constants for the SDRAM power-up initialization sequencer.
// State encoding, command encodings and the wait-counter width live here.
package sdram_init_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_PWRUP    = 3'd0,
    ST_PRE      = 3'd1,
    ST_WAIT_RP  = 3'd2,
    ST_REF      = 3'd3,
    ST_WAIT_RFC = 3'd4,
    ST_LMR      = 3'd5,
    ST_WAIT_MRD = 3'd6,
    ST_DONE     = 3'd7
  } init_state_e;

  // Command encodings as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

endpackage

// File: rtl/sdram_init_seq_gen_if.sv
// SDRAM command-pin bundle plus the init sequencer's config/request/status signals.
// The master modport is the sequencer; the slave modport is whoever consumes the pins.
interface sdram_init_seq_gen_if;

  logic [12:0] cfg_sdr_mode_reg;
  logic        init_req;
  logic        sdr_cke;
  logic        sdr_cs_n;
  logic        sdr_ras_n;
  logic        sdr_cas_n;
  logic        sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [12:0] sdr_addr;
  logic        sdr_init_done;
  logic [2:0]  init_state;

  modport master (
    input  cfg_sdr_mode_reg, init_req,
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    output sdr_ba, sdr_addr, sdr_init_done, init_state
  );

  modport slave (
    output cfg_sdr_mode_reg, init_req,
    input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    input  sdr_ba, sdr_addr, sdr_init_done, init_state
  );

endinterface

// File: rtl/sdram_init_seq_gen.sv
// SDRAM power-up init sequencer: NOP window, PRECHARGE-ALL, N AUTO-REFRESH, LOAD MODE, done.
// Outputs are registered from the next state, so state and pins of a cycle always agree.
module sdram_init_seq_gen
  import sdram_init_pkg::*;
#(
  parameter int T_PWRUP   = 500,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int N_REFRESH = 2,
  parameter int T_MRD     = 2
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  sdram_init_seq_gen_if.master bus
);

  if (T_PWRUP < 1 || T_PWRUP > 65535 || T_RP < 1 || T_RP > 65535 ||
      T_RFC < 1 || T_RFC > 65535 || N_REFRESH < 1 || N_REFRESH > 15 ||
      T_MRD < 1 || T_MRD > 65535) begin : g_bad_param
    $fatal(1, "sdram_init_seq_gen: illegal timing parameter");
  end

  init_state_e      r_state;
  init_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_ref_cnt;
  logic             w_last_ref;
  logic             r_cke;
  logic [3:0]       r_cmd;
  logic [1:0]       r_ba;
  logic [12:0]      r_addr;
  logic             r_init_done;

  assign w_last_ref = (r_ref_cnt == 4'(N_REFRESH));

  // Each command cycle is the first cycle of its window; the wait states cover the rest.
  // PWRUP also spans the reset period, hence the compare against T_PWRUP itself.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      ST_PWRUP:    if (r_cnt == CNT_W'(T_PWRUP)) w_state_nxt = ST_PRE;
      ST_PRE:      w_state_nxt = (T_RP == 1) ? ST_REF : ST_WAIT_RP;
      ST_WAIT_RP:  if (r_cnt == CNT_W'(T_RP - 2)) w_state_nxt = ST_REF;
      ST_REF: begin
        if (T_RFC == 1) w_state_nxt = w_last_ref ? ST_LMR : ST_REF;
        else            w_state_nxt = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: if (r_cnt == CNT_W'(T_RFC - 2)) w_state_nxt = w_last_ref ? ST_LMR : ST_REF;
      ST_LMR:      w_state_nxt = (T_MRD == 1) ? ST_DONE : ST_WAIT_MRD;
      ST_WAIT_MRD: if (r_cnt == CNT_W'(T_MRD - 2)) w_state_nxt = ST_DONE;
      ST_DONE:     if (bus.init_req) w_state_nxt = ST_PRE;
      default:     w_state_nxt = ST_PWRUP;
    endcase
    if (w_state_nxt != r_state || r_state == ST_DONE) w_cnt_nxt = '0;
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state   <= ST_PWRUP;
      r_cnt     <= '0;
      r_ref_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_state_nxt == ST_PRE)      r_ref_cnt <= '0;
      else if (w_state_nxt == ST_REF) r_ref_cnt <= r_ref_cnt + 4'd1;
    end
  end

  // Pin registers: NOP with ba/addr at zero unless the next state issues a command.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_cke       <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_ba        <= '0;
      r_addr      <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_cke       <= 1'b1;
      r_cmd       <= CMD_NOP;
      r_ba        <= '0;
      r_addr      <= '0;
      r_init_done <= (w_state_nxt == ST_DONE);
      case (w_state_nxt)
        ST_PRE: begin
          r_cmd  <= CMD_PRE;
          r_addr <= 13'h0400;
        end
        ST_REF:  r_cmd <= CMD_REF;
        ST_LMR: begin
          r_cmd  <= CMD_LMR;
          r_addr <= bus.cfg_sdr_mode_reg;
        end
        default: r_cmd <= CMD_NOP;
      endcase
    end
  end

  assign bus.sdr_cke       = r_cke;
  assign bus.sdr_cs_n      = r_cmd[3];
  assign bus.sdr_ras_n     = r_cmd[2];
  assign bus.sdr_cas_n     = r_cmd[1];
  assign bus.sdr_we_n      = r_cmd[0];
  assign bus.sdr_ba        = r_ba;
  assign bus.sdr_addr      = r_addr;
  assign bus.sdr_init_done = r_init_done;
  assign bus.init_state    = r_state;

endmodule

// File: tb/tb_sdram_init_seq_gen.sv
// Scoreboard bench for sdram_init_seq_gen: a default-timing and a minimal-timing instance
// share reset/init_req/cfg; expected pins come from the cycle map, compared every cycle.
module tb_sdram_init_seq_gen;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        done;
  } exp_t;

  typedef struct {
    exp_t e;
    int   cyc;
  } item_t;

  typedef struct {
    int pwrup;
    int rp;
    int rfc;
    int nref;
    int mrd;
  } tm_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;
  int          g = 0;
  int          run_base = 0;
  int          scen = 0;
  bit          in_reset = 1'b0;
  bit          req_drv = 1'b0;
  logic [12:0] cfg_drv = 13'h033;
  tm_t         tm [2];
  int          start [2];
  bit          pw [2];
  bit          done_prev [2];
  item_t       q0 [$];
  item_t       q1 [$];

  always #5 clk = ~clk;

  sdram_init_seq_gen_if bus0 ();
  sdram_init_seq_gen_if bus1 ();

  sdram_init_seq_gen #(.T_PWRUP(500), .T_RP(2), .T_RFC(7), .N_REFRESH(2), .T_MRD(2)) u_dut0 (
    .sdram_clk(clk), .sdram_resetn(resetn), .bus(bus0));

  sdram_init_seq_gen #(.T_PWRUP(4), .T_RP(1), .T_RFC(1), .N_REFRESH(1), .T_MRD(1)) u_dut1 (
    .sdram_clk(clk), .sdram_resetn(resetn), .bus(bus1));

  // Cycle map: t is cycles since sequence start; pw selects the power-up NOP window.
  function automatic exp_t model_out(input tm_t m, input int t, input bit pwr, input logic [12:0] cfg);
    exp_t e;
    int   p;
    int   l;
    p = pwr ? m.pwrup : 0;
    l = p + m.rp + m.nref * m.rfc;
    e.cke  = 1'b1;
    e.cmd  = 4'b1111;
    e.ba   = 2'd0;
    e.addr = 13'd0;
    e.done = (t >= l + m.mrd);
    if (t == p) begin
      e.cmd  = 4'b0010;
      e.addr = 13'h0400;
    end
    for (int k = 0; k < m.nref; k++)
      if (t == p + m.rp + k * m.rfc) e.cmd = 4'b0001;
    if (t == l) begin
      e.cmd  = 4'b0000;
      e.addr = cfg;
    end
    return e;
  endfunction

  function automatic int lmr_abs(input int d);
    return start[d] + (pw[d] ? tm[d].pwrup : 0) + tm[d].rp + tm[d].nref * tm[d].rfc;
  endfunction

  task automatic step(input bit do_assert, input bit do_release);
    int  rel;
    bit  req;
    bit  hold;
    item_t it;
    @(posedge clk);
    #1;
    g++;
    if (do_assert) begin
      resetn   = 1'b0;
      in_reset = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      if (in_reset) begin
        it.e      = '0;
        it.e.cmd  = 4'b1111;
      end else begin
        if (req_drv && done_prev[d]) begin
          start[d] = g;
          pw[d]    = 1'b0;
        end
        it.e = model_out(tm[d], g - start[d], pw[d], cfg_drv);
      end
      it.cyc       = g;
      done_prev[d] = it.e.done;
      if (d == 0) q0.push_back(it);
      else        q1.push_back(it);
    end
    if (do_release) begin
      resetn   = 1'b1;
      in_reset = 1'b0;
      run_base = g + 1;
      for (int d = 0; d < 2; d++) begin
        start[d] = g + 1;
        pw[d]    = 1'b1;
      end
    end
    rel = g - run_base;
    req = 1'b0;
    if (!in_reset && !do_release) begin
      if (scen == 1)
        req = (rel == 300 || rel == 600 || rel == 612 || rel == 618 || rel == 700 ||
               (rel > 720 && $urandom_range(39) == 0));
      else
        req = (rel >= 520 && $urandom_range(29) == 0);
    end
    req_drv = req;
    bus0.init_req = req;
    bus1.init_req = req;
    hold = in_reset;
    for (int d = 0; d < 2; d++)
      if (!in_reset && lmr_abs(d) >= g && lmr_abs(d) <= g + 2) hold = 1'b1;
    if (scen == 1 && rel < 517) cfg_drv = 13'h033;
    else if (scen == 1 && rel == 517) cfg_drv = 13'h022;
    else if (!hold) cfg_drv = 13'($urandom);
    bus0.cfg_sdr_mode_reg = cfg_drv;
    bus1.cfg_sdr_mode_reg = cfg_drv;
  endtask

  task automatic cmp(input int d, input item_t it, input exp_t act);
    n_checks++;
    if (act !== it.e) begin
      n_errors++;
      $display("FAIL dut%0d pins cycle %0d: got cke=%b cmd=%b ba=%0d addr=%h done=%b, expected cke=%b cmd=%b ba=%0d addr=%h done=%b",
               d, it.cyc, act.cke, act.cmd, act.ba, act.addr, act.done,
               it.e.cke, it.e.cmd, it.e.ba, it.e.addr, it.e.done);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    exp_t  act;
    if (q0.size() > 0) begin
      it  = q0.pop_front();
      act = {bus0.sdr_cke, bus0.sdr_cs_n, bus0.sdr_ras_n, bus0.sdr_cas_n, bus0.sdr_we_n,
             bus0.sdr_ba, bus0.sdr_addr, bus0.sdr_init_done};
      cmp(0, it, act);
    end
    if (q1.size() > 0) begin
      it  = q1.pop_front();
      act = {bus1.sdr_cke, bus1.sdr_cs_n, bus1.sdr_ras_n, bus1.sdr_cas_n, bus1.sdr_we_n,
             bus1.sdr_ba, bus1.sdr_addr, bus1.sdr_init_done};
      cmp(1, it, act);
    end
  end

  initial begin
    tm[0] = '{pwrup: 500, rp: 2, rfc: 7, nref: 2, mrd: 2};
    tm[1] = '{pwrup: 4,   rp: 1, rfc: 1, nref: 1, mrd: 1};
    for (int d = 0; d < 2; d++) begin
      start[d]     = 0;
      pw[d]        = 1'b1;
      done_prev[d] = 1'b0;
    end
    bus0.init_req = 1'b0;
    bus1.init_req = 1'b0;
    bus0.cfg_sdr_mode_reg = 13'h033;
    bus1.cfg_sdr_mode_reg = 13'h033;
    #2;
    resetn   = 1'b0;
    in_reset = 1'b1;
    scen     = 1;
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (1500) step(1'b0, 1'b0);

    scen = 2;
    repeat (505) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (900) step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() + q1.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
